// File: rtl/ifu_bus_pkg.sv
// Shared definitions for the instruction-fetch IO bus.
//   imem_state_t  : responder FSM encoding (IDLE -> WAIT -> RESP)
//   IMEM_ERR_DATA : default word returned on an error response; all-zero
//                   decodes as an illegal instruction
//   IMEM_CNT_W    : latency counter width; 4 bits covers LATENCY 1..15
package ifu_bus_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_t;

    localparam logic [31:0] IMEM_ERR_DATA = 32'h0000_0000;
    localparam int          IMEM_CNT_W    = 4;

endpackage

// File: rtl/imem_sram_1w1r.sv
// Word-organised instruction memory, one write port and one synchronous read
// port. On a same-address collision the read returns the old contents
// (read-before-write). rdata only changes on a read strobe, so a later write
// to the same word leaves an already-fetched word untouched.
// Ports:
//   clock : posedge clock
//   we    : write enable;  waddr/wdata : write word index / data
//   re    : read strobe;   raddr       : read word index
//   rdata : registered read data
module imem_sram_1w1r #(
    parameter int DEPTH = 4096,
    parameter int WIDTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a read at the same edge as a write
    // to the same index sees the pre-write word.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Responder end of the instruction-fetch IO bus. Serves IFU fetches out of a
// word-organised memory with a fixed, parameterised response latency, and
// provides a side load port for filling the memory.
// Handshake: a request is io_reqValid=1 with io_addr stable in that cycle; it
// is accepted at the next edge when the responder is IDLE or RESP. The
// response is a single-cycle io_respValid pulse LATENCY cycles after the
// request cycle, carrying io_rdata/io_err. There is no back-pressure; a new
// rising edge of io_reqValid while WAITing is dropped and flagged.
// Ports:
//   clock, reset               : clock, synchronous active-high reset
//   io_reqValid, io_addr       : fetch request and byte address
//   io_respValid, io_rdata,
//   io_err                     : response pulse, data word, error flag
//   load_wen, load_addr,
//   load_wdata                 : memory load port (same address map)
//   busy                       : a request is outstanding
//   drop_sticky                : a request was dropped since reset
module imem_responder
    import ifu_bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] ERR_DATA    = IMEM_ERR_DATA
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_reqValid,
    input  logic [31:0] io_addr,
    output logic        io_respValid,
    output logic [31:0] io_rdata,
    output logic        io_err,
    input  logic        load_wen,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata,
    output logic        busy,
    output logic        drop_sticky
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IMEM_CNT_W-1:0] CNT_INIT = IMEM_CNT_W'(LATENCY - 1);
    localparam logic [IMEM_CNT_W-1:0] CNT_ONE  = IMEM_CNT_W'(1);
    localparam bit LAT_ONE = (LATENCY == 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("imem_responder: LATENCY must be in 1..15");
        end
    endgenerate

    imem_state_t           state, state_next;
    logic [IMEM_CNT_W-1:0] cnt, cnt_next;
    logic                  err_q;
    logic                  req_prev;

    // Offsets are taken on the full 32 bits so an address below BASE_ADDR
    // wraps to a huge offset and fails the range check. Because BASE_ADDR is
    // aligned, offset[1:0] equals addr[1:0].
    logic [31:0]      fetch_off, load_off;
    logic             fetch_ok, load_ok;
    logic [IDX_W-1:0] fetch_idx, load_idx;
    logic             accept;
    logic [31:0]      sram_rdata;

    assign fetch_off = io_addr - BASE_ADDR;
    assign load_off  = load_addr - BASE_ADDR;
    assign fetch_ok  = (fetch_off[1:0] == 2'b00) && (fetch_off[31:IDX_W+2] == '0);
    assign load_ok   = (load_off[1:0] == 2'b00) && (load_off[31:IDX_W+2] == '0);
    assign fetch_idx = fetch_off[IDX_W+1:2];
    assign load_idx  = load_off[IDX_W+1:2];

    // RESP accepts like IDLE, which gives back-to-back fetches.
    assign accept = io_reqValid && (state == IMEM_IDLE || state == IMEM_RESP);

    imem_sram_1w1r #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (32)
    ) u_sram (
        .clock (clock),
        .we    (load_wen && load_ok),
        .waddr (load_idx),
        .wdata (load_wdata),
        .re    (accept && fetch_ok),
        .raddr (fetch_idx),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IMEM_IDLE, IMEM_RESP: begin
                if (io_reqValid) begin
                    if (LAT_ONE) begin
                        state_next = IMEM_RESP;
                    end else begin
                        state_next = IMEM_WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end else begin
                    state_next = IMEM_IDLE;
                end
            end
            IMEM_WAIT: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_next = IMEM_RESP;
                end
            end
            default: begin
                state_next = IMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IMEM_IDLE;
            cnt         <= '0;
            err_q       <= 1'b0;
            req_prev    <= 1'b0;
            drop_sticky <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            req_prev <= io_reqValid;
            if (accept) begin
                err_q <= !fetch_ok;
            end
            // A request held high from acceptance through WAIT is one
            // request; only a fresh rising edge during WAIT is a drop.
            if (state == IMEM_WAIT && io_reqValid && !req_prev) begin
                drop_sticky <= 1'b1;
            end
        end
    end

    // The SRAM read register is the response data register; on an error no
    // read is issued and ERR_DATA is substituted here instead.
    assign io_respValid = (state == IMEM_RESP);
    assign io_err       = io_respValid && err_q;
    assign io_rdata     = !io_respValid ? 32'h0000_0000 :
                          err_q         ? ERR_DATA      : sram_rdata;
    assign busy         = (state != IMEM_IDLE);

endmodule
